// File: rtl/mon_pkg.sv
// Shared types and helpers for the pipelined-core retirement monitor.
// Widths in commit_t are the maximum supported; narrower buses are zero-extended.
package mon_pkg;

  localparam int unsigned MON_MAX_CH = 32;
  localparam int unsigned MON_MAX_W  = 64;

  typedef enum logic [1:0] {RUN, HALTED, TIMEDOUT} mon_state_e;

  typedef struct packed {
    logic                 valid;
    logic [MON_MAX_W-1:0] pc;
    logic [MON_MAX_W-1:0] pc_next;
    logic                 is_ctl;
    logic                 rd_we;
    logic [4:0]           rd_addr;
    logic                 mem_rd;
    logic                 mem_wr;
  } commit_t;

  function automatic logic [7:0] popcount(input logic [MON_MAX_CH-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < MON_MAX_CH; i++) n = n + {7'd0, v[i]};
    return n;
  endfunction

  // Adds a small increment and clamps at lim instead of wrapping.
  function automatic logic [MON_MAX_W-1:0] sat_add(input logic [MON_MAX_W-1:0] a,
                                                   input logic [7:0]           b,
                                                   input logic [MON_MAX_W-1:0] lim);
    logic [MON_MAX_W:0] s;
    s = {1'b0, a} + {{(MON_MAX_W-7){1'b0}}, b};
    if (s > {1'b0, lim}) return lim;
    return s[MON_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/mon_trace_ring.sv
// Ring of the most recent committed PCs, NUM_CH write ports in channel order,
// one combinational read port indexed from the newest entry.
module mon_trace_ring #(
  parameter int NUM_CH     = 1,
  parameter int XLEN       = 32,
  parameter int HIST_DEPTH = 16,
  localparam int IDX_W     = $clog2(HIST_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_we,
  input  logic [NUM_CH-1:0]      i_valid,
  input  logic [NUM_CH*XLEN-1:0] i_pc,
  input  logic [IDX_W-1:0]       i_idx,
  output logic [XLEN-1:0]        o_pc
);

  logic [XLEN-1:0]  r_mem [HIST_DEPTH];
  logic [IDX_W-1:0] r_wp;
  logic [IDX_W-1:0] w_slot [NUM_CH];
  logic [IDX_W-1:0] w_wp_next;
  logic [IDX_W-1:0] w_rd;

  // Assign consecutive slots to valid channels, oldest channel first.
  always_comb begin
    w_wp_next = r_wp;
    for (int i = 0; i < NUM_CH; i++) begin
      w_slot[i] = w_wp_next;
      if (i_valid[i]) w_wp_next = w_wp_next + IDX_W'(1);
    end
  end

  // Write committed PCs; cleared entries make never-written slots read 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < HIST_DEPTH; k++) r_mem[k] <= '0;
      r_wp <= '0;
    end else if (i_we) begin
      for (int i = 0; i < NUM_CH; i++)
        if (i_valid[i]) r_mem[w_slot[i]] <= i_pc[i*XLEN +: XLEN];
      r_wp <= w_wp_next;
    end
  end

  assign w_rd = r_wp - IDX_W'(1) - i_idx;
  assign o_pc = r_mem[w_rd];

endmodule

// File: rtl/pipe_commit_monitor.sv
// Retirement monitor: commit/regwrite/load/store counters, self-branch halt
// detection and no-commit watchdog. Optional PC trace ring under MON_TRACE_EN.
module pipe_commit_monitor
  import mon_pkg::*;
#(
  parameter int NUM_CH      = 1,
  parameter int XLEN        = 32,
  parameter int CNT_W       = 64,
  parameter int HALT_REPEAT = 1,
  parameter int TIMEOUT_CYC = 100000000,
  parameter int HIST_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             commit_valid,
  input  logic [NUM_CH*XLEN-1:0]        commit_pc,
  input  logic [NUM_CH*XLEN-1:0]        commit_pc_next,
  input  logic [NUM_CH-1:0]             commit_is_ctl,
  input  logic [NUM_CH-1:0]             commit_rd_we,
  input  logic [NUM_CH*5-1:0]           commit_rd_addr,
  input  logic [NUM_CH-1:0]             commit_mem_rd,
  input  logic [NUM_CH-1:0]             commit_mem_wr,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [CNT_W-1:0]              order,
  output logic [CNT_W-1:0]              regwr_cnt,
  output logic [CNT_W-1:0]              load_cnt,
  output logic [CNT_W-1:0]              store_cnt,
  output logic                          halt,
  output logic                          timeout,
  output logic [XLEN-1:0]               hist_pc
);

  localparam int STK_W  = $clog2(HALT_REPEAT + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [MON_MAX_W-1:0] CNT_MAX =
    (CNT_W >= MON_MAX_W) ? '1 : ((64'd1 << CNT_W) - 64'd1);

  commit_t           w_ch [NUM_CH];
  logic [NUM_CH-1:0] w_v, w_rw, w_ld, w_st;
  logic [STK_W-1:0]  w_streak;
  logic              w_halt_hit;
  logic              w_any;

  mon_state_e        r_state;
  logic [CNT_W-1:0]  r_order, r_regwr, r_load, r_store;
  logic [STK_W-1:0]  r_streak;
  logic [IDLE_W-1:0] r_idle;
  logic              r_halt, r_timeout;

  // Unpack the flat channel buses and build per-event qualifier masks.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_ch[i].valid   = commit_valid[i];
      w_ch[i].pc      = MON_MAX_W'(commit_pc[i*XLEN +: XLEN]);
      w_ch[i].pc_next = MON_MAX_W'(commit_pc_next[i*XLEN +: XLEN]);
      w_ch[i].is_ctl  = commit_is_ctl[i];
      w_ch[i].rd_we   = commit_rd_we[i];
      w_ch[i].rd_addr = commit_rd_addr[i*5 +: 5];
      w_ch[i].mem_rd  = commit_mem_rd[i];
      w_ch[i].mem_wr  = commit_mem_wr[i];
      w_v[i]  = w_ch[i].valid;
      w_rw[i] = w_ch[i].valid & w_ch[i].rd_we & (w_ch[i].rd_addr != 5'd0);
      w_ld[i] = w_ch[i].valid & w_ch[i].mem_rd;
      w_st[i] = w_ch[i].valid & w_ch[i].mem_wr;
    end
  end

  // Walk channels oldest-first so a later non-branch breaks an earlier streak.
  always_comb begin
    w_streak   = r_streak;
    w_halt_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch[i].valid) begin
        if (w_ch[i].is_ctl && (w_ch[i].pc_next == w_ch[i].pc)) begin
          if (w_streak != STK_W'(HALT_REPEAT)) w_streak = w_streak + STK_W'(1);
          if (w_streak == STK_W'(HALT_REPEAT)) w_halt_hit = 1'b1;
        end else begin
          w_streak = '0;
        end
      end
    end
  end

  assign w_any = |w_v;

  // Monitor FSM with counters; everything freezes once halted or timed out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RUN;
      r_order   <= '0;
      r_regwr   <= '0;
      r_load    <= '0;
      r_store   <= '0;
      r_streak  <= '0;
      r_idle    <= '0;
      r_halt    <= 1'b0;
      r_timeout <= 1'b0;
    end else if (r_state == RUN) begin
      r_order  <= CNT_W'(sat_add(MON_MAX_W'(r_order), popcount(MON_MAX_CH'(w_v)),  CNT_MAX));
      r_regwr  <= CNT_W'(sat_add(MON_MAX_W'(r_regwr), popcount(MON_MAX_CH'(w_rw)), CNT_MAX));
      r_load   <= CNT_W'(sat_add(MON_MAX_W'(r_load),  popcount(MON_MAX_CH'(w_ld)), CNT_MAX));
      r_store  <= CNT_W'(sat_add(MON_MAX_W'(r_store), popcount(MON_MAX_CH'(w_st)), CNT_MAX));
      r_streak <= w_streak;
      r_idle   <= w_any ? '0 : r_idle + IDLE_W'(1);
      if (w_halt_hit) begin
        r_state <= HALTED;
        r_halt  <= 1'b1;
      end else if (r_idle == IDLE_W'(TIMEOUT_CYC - 1)) begin
        r_state   <= TIMEDOUT;
        r_timeout <= 1'b1;
      end
    end
  end

  assign order     = r_order;
  assign regwr_cnt = r_regwr;
  assign load_cnt  = r_load;
  assign store_cnt = r_store;
  assign halt      = r_halt;
  assign timeout   = r_timeout;

`ifdef MON_TRACE_EN
  mon_trace_ring #(
    .NUM_CH    (NUM_CH),
    .XLEN      (XLEN),
    .HIST_DEPTH(HIST_DEPTH)
  ) u_ring (
    .clk    (clk),
    .reset  (reset),
    .i_we   (r_state == RUN),
    .i_valid(w_v),
    .i_pc   (commit_pc),
    .i_idx  (hist_idx),
    .o_pc   (hist_pc)
  );
`else
  logic w_unused_idx;
  assign w_unused_idx = ^hist_idx;
  assign hist_pc      = '0;
`endif

endmodule
